id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode pipeline stage that sits directly upstream of the execute-stage ALU. It accepts a fetched RV32I instruction and its PC over a valid/ready handshake, and reads `rs1`/`rs2` from the register file's asynchronous read ports. It decodes the instruction into the ALU's 4-bit operation code and selected operands, plus control bits. The result is registered into a single output pipeline slot with backpressure and flush.

## Interface
- Parameters: none (RV32I, 32-bit datapath fixed)
- `clk` in 1: single clock, all state updates on rising edge
- `rstn` in 1: synchronous reset, active-low
- `in_valid` in 1: fetch presents `in_instr`/`in_pc`
- `in_ready` out 1: stage accepts input this cycle
- `in_instr` in 32: instruction word
- `in_pc` in 32: instruction address
- `rs1_addr`, `rs2_addr` out 5 each: combinational from `in_instr[19:15]`, `[24:20]`
- `rs1_data`, `rs2_data` in 32 each: register-file read data (combinational)
- `flush` in 1: discard held and incoming instruction
- `out_valid` out 1: decoded bundle valid
- `out_ready` in 1: execute consumes bundle
- `aluop` out 4: 0 ADD, 1 SUB, 2 SLT, 3 XOR, 4 AND, 5 OR, 6 SLL, 7 SRL, 8 SRA, 9 EQ→1, 10 LT→0, 11 GE→0
- `src0`, `src1` out 32: ALU operands
- `imm` out 32: sign-extended immediate (branch/jump offset, load/store offset)
- `store_data` out 32: `rs2_data` captured at accept
- `pc` out 32: captured `in_pc`
- `rd` out 5; `reg_we`, `mem_read`, `mem_write`, `is_branch`, `is_jump`, `is_jalr`, `illegal` out 1 each

## Operation
- Branch convention: ALU `flag` (result==0) means taken for all branches. BEQ→SUB, BNE→9, BLT→10, BGE→11; `src0=rs1_data`, `src1=rs2_data`, `imm`=B-imm, `reg_we=0`.
- OP (0110011): funct7 0000000 → ADD/SLL/SLT/XOR/SRL/OR/AND by funct3. funct7 0100000 with funct3 000 → SUB, with 101 → SRA. Any other combination, and SLTU, is illegal. `src1=rs2_data`.
- OP-IMM (0010011): ADDI/SLTI/XORI/ORI/ANDI, with `src1`=I-imm. SLLI/SRLI/SRAI require funct7 0000000/0000000/0100000, else illegal. SLTIU is illegal.
- LUI: ADD, `src0=0`, `src1`=U-imm. AUIPC: ADD, `src0=in_pc`, `src1`=U-imm.
- JAL: ADD, `src0=in_pc`, `src1=4`, `imm`=J-imm, `is_jump=1`.
- JALR: same as JAL, but `imm`=I-imm, `is_jalr=1`, and `src0`/`src1` still give the link value. Target = `rs1_data+imm` is computed downstream, so `store_data` carries `rs1_data` for JALR.
- LW only (funct3 010): ADD, `src0=rs1_data`, `src1`=I-imm, `mem_read=1`. SW only (funct3 010): ADD, `src1`=S-imm, `mem_write=1`. Other widths are illegal.
- `reg_we=1` for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LW. It is forced to 0 when `rd==0`.
- Illegal or unknown opcode: `illegal=1`, `aluop=0`, and all enables/`is_*` bits are 0. The bundle is still delivered with `out_valid=1` so downstream can trap.
- Operands are sampled at accept time. Hazard/forwarding is handled downstream; this block does not stall on dependencies.

## Timing
- Latency 1: input accepted at edge N appears on outputs after edge N. Throughput is 1 instruction/cycle.
- `in_ready = !out_valid || out_ready || flush` (combinational).
- Accept when `in_valid && in_ready && !flush`: load all output registers and set `out_valid=1`.
- No accept and `out_ready`: `out_valid` goes to 0; data registers hold.
- `out_valid && !out_ready`: all outputs hold stable (no change to any output).
- `flush` has priority: next cycle `out_valid=0`. Any simultaneous input is consumed (`in_ready=1`) and dropped.
- Reset (`rstn=0` at edge): every output register goes to 0, including `out_valid`, `aluop`, `src0`, `src1`, `imm`, `pc`, `rd`, and all flags. This applies mid-stall too; the held bundle is lost.
- `rs1_addr`/`rs2_addr` are purely combinational from `in_instr`, independent of reset.

## Test plan
- `add x3,x1,x2` with rs1=5, rs2=7, `out_ready=1` → next cycle `out_valid=1`, `aluop=0`, `src0=5`, `src1=7`, `rd=3`, `reg_we=1`.
- `blt x1,x2,-8` with rs1=-1, rs2=1 → `aluop=10`, `is_branch=1`, `imm=0xFFFFFFF8`, `reg_we=0`. The ALU `flag` is then 1.
- `auipc x5,0x12345` at pc 0x100 → `aluop=0`, `src0=0x100`, `src1=0x12345000`. Then `jal x0,16` → `is_jump=1`, `src1=4`, `reg_we=0`.
- Backpressure: hold `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0`, outputs unchanged. Release → the next instruction is accepted in that cycle and appears one cycle later.
- `flush=1` while `out_valid=1` and `in_valid=1` → next cycle `out_valid=0`, `in_ready` was 1, and the instruction is not delivered.
- Illegal inputs: `sltu` (0x0020B1B3) and opcode 0x7F → `illegal=1`, `aluop=0`, `reg_we=0`, `out_valid=1`. Assert `rstn=0` during a stall → all outputs read 0 next cycle.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage feeding the execute ALU through a single registered slot
// with valid/ready backpressure and flush.
module id_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  aluop,
    output logic [31:0] src0,
    output logic [31:0] src1,
    output logic [31:0] imm,
    output logic [31:0] store_data,
    output logic [31:0] pc,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic        mem_read,
    output logic        mem_write,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_jalr,
    output logic        illegal
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rdf;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [3:0]  f3op;
    logic [3:0]  d_aluop;
    logic [31:0] d_src0, d_src1, d_imm, d_sd;
    logic        d_we, d_mr, d_mw, d_br, d_j, d_jr, d_ill;
    logic        accept;

    assign opc      = in_instr[6:0];
    assign rdf      = in_instr[11:7];
    assign f3       = in_instr[14:12];
    assign f7       = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    assign i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
    assign s_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign b_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign u_imm = {in_instr[31:12], 12'b0};
    assign j_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // funct3 -> ALU op shared by OP and OP-IMM; 011 (unsigned compare) is rejected separately
    assign f3op = f3 == 3'b000 ? 4'd0 : f3 == 3'b001 ? 4'd6 : f3 == 3'b010 ? 4'd2 :
                  f3 == 3'b100 ? 4'd3 : f3 == 3'b101 ? 4'd7 : f3 == 3'b110 ? 4'd5 : 4'd4;

    assign in_ready = !out_valid || out_ready || flush;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        d_aluop = 4'd0;
        d_src0  = rs1_data;
        d_src1  = rs2_data;
        d_imm   = 32'd0;
        d_sd    = rs2_data;
        d_we    = 1'b0;
        d_mr    = 1'b0;
        d_mw    = 1'b0;
        d_br    = 1'b0;
        d_j     = 1'b0;
        d_jr    = 1'b0;
        d_ill   = 1'b0;
        case (opc)
            OP_R: begin
                d_ill   = f3 == 3'b011 || !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
                d_aluop = f7[5] ? (f3 == 3'b000 ? 4'd1 : 4'd8) : f3op;
                d_we    = 1'b1;
            end
            OP_I: begin
                d_ill   = f3 == 3'b011 || (f3 == 3'b001 && f7 != 7'b0000000) ||
                          (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
                d_aluop = (f3 == 3'b101 && f7[5]) ? 4'd8 : f3op;
                d_src1  = i_imm;
                d_imm   = i_imm;
                d_we    = 1'b1;
            end
            LUI: begin
                d_src0 = 32'd0;
                d_src1 = u_imm;
                d_imm  = u_imm;
                d_we   = 1'b1;
            end
            AUIPC: begin
                d_src0 = in_pc;
                d_src1 = u_imm;
                d_imm  = u_imm;
                d_we   = 1'b1;
            end
            JAL: begin
                d_src0 = in_pc;
                d_src1 = 32'd4;
                d_imm  = j_imm;
                d_we   = 1'b1;
                d_j    = 1'b1;
            end
            // link value through the ALU; the jump base rides on store_data
            JALR: begin
                d_src0 = in_pc;
                d_src1 = 32'd4;
                d_imm  = i_imm;
                d_sd   = rs1_data;
                d_we   = 1'b1;
                d_jr   = 1'b1;
            end
            BRANCH: begin
                d_ill   = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101);
                d_aluop = f3 == 3'b000 ? 4'd1 : f3 == 3'b001 ? 4'd9 : f3 == 3'b100 ? 4'd10 : 4'd11;
                d_imm   = b_imm;
                d_br    = 1'b1;
            end
            LOAD: begin
                d_ill  = f3 != 3'b010;
                d_src1 = i_imm;
                d_imm  = i_imm;
                d_we   = 1'b1;
                d_mr   = 1'b1;
            end
            STORE: begin
                d_ill  = f3 != 3'b010;
                d_src1 = s_imm;
                d_imm  = s_imm;
                d_mw   = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_aluop = 4'd0;
            d_we    = 1'b0;
            d_mr    = 1'b0;
            d_mw    = 1'b0;
            d_br    = 1'b0;
            d_j     = 1'b0;
            d_jr    = 1'b0;
        end
        if (rdf == 5'd0)
            d_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            aluop      <= 4'd0;
            src0       <= 32'd0;
            src1       <= 32'd0;
            imm        <= 32'd0;
            store_data <= 32'd0;
            pc         <= 32'd0;
            rd         <= 5'd0;
            reg_we     <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            is_branch  <= 1'b0;
            is_jump    <= 1'b0;
            is_jalr    <= 1'b0;
            illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            aluop      <= d_aluop;
            src0       <= d_src0;
            src1       <= d_src1;
            imm        <= d_imm;
            store_data <= d_sd;
            pc         <= in_pc;
            rd         <= rdf;
            reg_we     <= d_we;
            mem_read   <= d_mr;
            mem_write  <= d_mw;
            is_branch  <= d_br;
            is_jump    <= d_j;
            is_jalr    <= d_jr;
            illegal    <= d_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed decode sequence with a scoreboard queue of expected bundles,
// compared whenever the stage presents a valid bundle.
module tb_id_stage;
    typedef struct packed {
        logic [3:0]  aluop;
        logic [31:0] src0, src1, imm, sd, pc;
        logic [4:0]  rd;
        logic [6:0]  f;
    } bund_t;
    typedef struct packed {
        bund_t e;
        bund_t m;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [3:0]  aluop;
    logic [31:0] src0, src1, imm, store_data, pc;
    logic        reg_we, mem_read, mem_write, is_branch, is_jump, is_jalr, illegal;
    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    ent_t        sw_e;

    id_stage dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .aluop(aluop), .src0(src0), .src1(src1), .imm(imm),
        .store_data(store_data), .pc(pc), .rd(rd), .reg_we(reg_we), .mem_read(mem_read),
        .mem_write(mem_write), .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic bund_t obs();
        return {aluop, src0, src1, imm, store_data, pc, rd,
                reg_we, mem_read, mem_write, is_branch, is_jump, is_jalr, illegal};
    endfunction

    // flags f = {reg_we, mem_read, mem_write, is_branch, is_jump, is_jalr, illegal}
    function automatic bund_t mk(logic [3:0] op, logic [31:0] s0, logic [31:0] s1, logic [31:0] im,
                                 logic [31:0] sd, logic [31:0] p, logic [4:0] r, logic [6:0] f);
        return {op, s0, s1, im, sd, p, r, f};
    endfunction

    // rd is a don't-care for branch/store; operands are don't-care for illegal instructions
    function automatic ent_t en(bund_t e, logic keep_rd, logic keep_ops);
        ent_t x;
        x.e = e;
        x.m = '1;
        if (!keep_rd) x.m.rd = '0;
        if (!keep_ops) begin
            x.m.src0 = '0;
            x.m.src1 = '0;
            x.m.imm  = '0;
            x.m.sd   = '0;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [175:0] got, input logic [175:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b, input logic ordy, input logic fl,
                         input logic rdy, input ent_t e);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        rs1_data  = a;
        rs2_data  = b;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk({tag, ".in_ready"}, in_ready, rdy);
        chk({tag, ".out_valid"}, out_valid, q.size() != 0);
        if (out_valid && q.size() != 0)
            chk({tag, ".bundle"}, obs() & q[0].m, q[0].e & q[0].m);
        if (fl) q.delete();
        else if (ordy && q.size() != 0) void'(q.pop_front());
        if (v && rdy && !fl) q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_instr = 32'h002081B3; in_pc = 32'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", out_valid, 1'b0);
        chk("reset.bundle", obs(), '0);
        chk("rs1_addr", rs1_addr, 5'd1);
        chk("rs2_addr", rs2_addr, 5'd2);
        rstn = 1'b1;
        drive("add",   1, 32'h002081B3, 32'h000, 5, 7, 1, 0, 1, en(mk(0, 5, 7, 0, 7, 32'h000, 3, 7'b1000000), 1, 1));
        drive("blt",   1, 32'hFE20CCE3, 32'h010, 32'hFFFFFFFF, 1, 1, 0, 1,
              en(mk(10, 32'hFFFFFFFF, 1, 32'hFFFFFFF8, 1, 32'h010, 0, 7'b0001000), 0, 1));
        drive("auipc", 1, 32'h12345297, 32'h100, 32'h55, 32'h66, 1, 0, 1,
              en(mk(0, 32'h100, 32'h12345000, 32'h12345000, 32'h66, 32'h100, 5, 7'b1000000), 1, 1));
        drive("jal",   1, 32'h0100006F, 32'h104, 0, 32'h77, 1, 0, 1,
              en(mk(0, 32'h104, 4, 16, 32'h77, 32'h104, 0, 7'b0000100), 1, 1));
        drive("sub",   1, 32'h402083B3, 32'h108, 9, 4, 1, 0, 1, en(mk(1, 9, 4, 0, 4, 32'h108, 7, 7'b1000000), 1, 1));
        drive("srai",  1, 32'h4030D413, 32'h10C, 32'h80000000, 0, 1, 0, 1,
              en(mk(8, 32'h80000000, 32'h403, 32'h403, 0, 32'h10C, 8, 7'b1000000), 1, 1));
        drive("bne",   1, 32'h00209463, 32'h110, 3, 3, 1, 0, 1, en(mk(9, 3, 3, 8, 3, 32'h110, 0, 7'b0001000), 0, 1));
        drive("jalr",  1, 32'h00C100E7, 32'h114, 32'h2000, 9, 1, 0, 1,
              en(mk(0, 32'h114, 4, 12, 32'h2000, 32'h114, 1, 7'b1000010), 1, 1));
        drive("lui",   1, 32'hABCDE4B7, 32'h118, 1, 2, 1, 0, 1,
              en(mk(0, 0, 32'hABCDE000, 32'hABCDE000, 2, 32'h118, 9, 7'b1000000), 1, 1));
        drive("add_x0", 1, 32'h00208033, 32'h11C, 1, 2, 1, 0, 1, en(mk(0, 1, 2, 0, 2, 32'h11C, 0, 7'b0000000), 1, 1));
        drive("addi",  1, 32'hFFD08213, 32'h120, 10, 0, 1, 0, 1,
              en(mk(0, 10, 32'hFFFFFFFD, 32'hFFFFFFFD, 0, 32'h120, 4, 7'b1000000), 1, 1));
        sw_e = en(mk(0, 32'h1000, 8, 8, 32'hAB, 32'h124, 0, 7'b0010000), 0, 1);
        for (int i = 0; i < 3; i++)
            drive("stall", 1, 32'h0020A423, 32'h124, 32'h1000, 32'hAB, 0, 0, 0, sw_e);
        drive("release", 1, 32'h0020A423, 32'h124, 32'h1000, 32'hAB, 1, 0, 1, sw_e);
        drive("flush", 1, 32'h0040A303, 32'h128, 32'h20, 5, 0, 1, 1, sw_e);
        drive("idle",  0, 32'h0, 32'h0, 0, 0, 1, 0, 1, sw_e);
        drive("lw",    1, 32'h0040A303, 32'h128, 32'h20, 5, 1, 0, 1,
              en(mk(0, 32'h20, 4, 4, 5, 32'h128, 6, 7'b1100000), 1, 1));
        drive("sltu",  1, 32'h0020B1B3, 32'h12C, 1, 2, 1, 0, 1, en(mk(0, 0, 0, 0, 0, 32'h12C, 3, 7'b0000001), 1, 0));
        drive("op7f",  1, 32'h0000007F, 32'h130, 1, 2, 1, 0, 1, en(mk(0, 0, 0, 0, 0, 32'h130, 0, 7'b0000001), 1, 0));
        drive("stall2", 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, sw_e);
        rstn = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        @(posedge clk);
        #1;
        chk("rst_stall.out_valid", out_valid, 1'b0);
        chk("rst_stall.bundle", obs(), '0);
        q.delete();
        rstn = 1'b1;
        drive("post", 0, 32'h0, 32'h0, 0, 0, 1, 0, 1, sw_e);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
